updn_counter_n: RTL and testbench

Parametrised, loadable up/down counter with terminal-count flags, selectable wrap/saturate behaviour and a programmable modulus. It generalises the fixed 16-bit up counter with UTC used in the lab top level. Its uses are time bases, BCD-style digit counters (MAX_VAL=9) and cascaded counter chains. It sits between the button/switch conditioning logic and the display multiplexer.

---
 rtl/counter_pkg.sv | 14 +
 rtl/updn_counter_n_edge_detect.sv | 27 ++
 rtl/updn_counter_n.sv | 122 ++++++++++++
 tb/tb_updn_counter_n.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and constants for the up/down counter slice.
// Holds the per-cycle operation encoding and the default counter width.
package counter_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_INC  = 2'd2,
        OP_DEC  = 2'd3
    } op_e;

endpackage

// File: rtl/updn_counter_n_edge_detect.sv
// One-bit rising-edge pulse generator for the step inputs.
// History resets to 1 so a level held through reset never fires.
module edge_detect (
    input  logic clkin,
    input  logic reset,
    input  logic d,
    output logic pulse
);

    logic hist_q;
    logic hist_d;

    always_comb begin
        hist_d = d;
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            hist_q <= 1'b1;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign pulse = d & ~hist_q;

endmodule

// File: rtl/updn_counter_n.sv
// Loadable up/down counter with terminal-count flags, wrap/saturate and modulus.
// Define UPDN_COUNTER_STEP_EDGE_EN for rising-edge detected step inputs.
module updn_counter_n
    import counter_pkg::*;
#(
    parameter int               WIDTH   = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             ce,
    input  logic             run,
    input  logic             up_step,
    input  logic             dn_step,
    input  logic             ld,
    input  logic [WIDTH-1:0] din,
    input  logic             sat,
    output logic [WIDTH-1:0] q,
    output logic             utc,
    output logic             dtc,
    output logic             wrap_pulse
);

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             up_step_e;
    logic             dn_step_e;
    logic             up_evt;
    logic             dn_evt;
    logic             at_max;
    logic             at_zero;
    op_e              op;

`ifdef UPDN_COUNTER_STEP_EDGE_EN
    edge_detect u_up_edge (
        .clkin (clkin),
        .reset (reset),
        .d     (up_step),
        .pulse (up_step_e)
    );

    edge_detect u_dn_edge (
        .clkin (clkin),
        .reset (reset),
        .d     (dn_step),
        .pulse (dn_step_e)
    );
`else
    assign up_step_e = up_step;
    assign dn_step_e = dn_step;
`endif

    assign up_evt  = run | up_step_e;
    assign dn_evt  = dn_step_e;
    assign at_max  = (q_q == MAX_VAL);
    assign at_zero = (q_q == ZERO);

    // Opposing up and down requests cancel to a hold.
    always_comb begin
        op = OP_HOLD;
        if (ld) begin
            op = OP_LOAD;
        end else if (ce && up_evt && !dn_evt) begin
            op = OP_INC;
        end else if (ce && dn_evt && !up_evt) begin
            op = OP_DEC;
        end
    end

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        unique case (op)
            OP_HOLD: begin
                q_d = q_q;
            end
            OP_LOAD: begin
                q_d = (din > MAX_VAL) ? MAX_VAL : din;
            end
            OP_INC: begin
                if (!at_max) begin
                    q_d = q_q + ONE;
                end else if (!sat) begin
                    q_d    = ZERO;
                    wrap_d = 1'b1;
                end
            end
            OP_DEC: begin
                if (!at_zero) begin
                    q_d = q_q - ONE;
                end else if (!sat) begin
                    q_d    = MAX_VAL;
                    wrap_d = 1'b1;
                end
            end
            default: begin
                q_d = q_q;
            end
        endcase
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            q_q    <= ZERO;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign q          = q_q;
    assign utc        = at_max;
    assign dtc        = at_zero;
    assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_updn_counter_n.sv
// Scoreboard bench for updn_counter_n: a 16-bit default instance and a
// 4-bit modulo-10 instance share stimulus and are checked against a model.
module tb_updn_counter_n;

    logic        clk;
    logic        reset;
    logic        ce;
    logic        run;
    logic        up_step;
    logic        dn_step;
    logic        ld;
    logic        sat;
    logic [15:0] din16;
    logic [3:0]  din4;
    logic [15:0] q16;
    logic        utc16, dtc16, wp16;
    logic [3:0]  q4;
    logic        utc4, dtc4, wp4;

    updn_counter_n u_dut16 (
        .clkin      (clk),
        .reset      (reset),
        .ce         (ce),
        .run        (run),
        .up_step    (up_step),
        .dn_step    (dn_step),
        .ld         (ld),
        .din        (din16),
        .sat        (sat),
        .q          (q16),
        .utc        (utc16),
        .dtc        (dtc16),
        .wrap_pulse (wp16)
    );

    updn_counter_n #(.WIDTH(4), .MAX_VAL(4'd9)) u_dut4 (
        .clkin      (clk),
        .reset      (reset),
        .ce         (ce),
        .run        (run),
        .up_step    (up_step),
        .dn_step    (dn_step),
        .ld         (ld),
        .din        (din4),
        .sat        (sat),
        .q          (q4),
        .utc        (utc4),
        .dtc        (dtc4),
        .wrap_pulse (wp4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int q16;
        bit u16, d16, w16;
        int q4;
        bit u4, d4, w4;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   m16 = 0;
    int   m4 = 0;
    bit   hist_up = 1'b1;
    bit   hist_dn = 1'b1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: counting modulo (max+1), clamped when saturating.
    function automatic int next_val(int cur, int max, int din_v, bit upe,
                                    bit dne, output bit w);
        int m;
        m = max + 1;
        w = 1'b0;
        if (ld) return (din_v > max) ? max : din_v;
        if (!ce || (upe == dne)) return cur;
        if (upe) begin
            if (sat) return (cur + 1 > max) ? max : cur + 1;
            w = (cur + 1 >= m);
            return (cur + 1) % m;
        end
        if (sat) return (cur - 1 < 0) ? 0 : cur - 1;
        w = (cur == 0);
        return (cur - 1 + m) % m;
    endfunction

    task automatic model_step();
        exp_t e;
        bit   us_e, ds_e, upe, dne, w16, w4;
        if (reset) begin
            m16 = 0; m4 = 0; w16 = 0; w4 = 0;
            hist_up = 1'b1; hist_dn = 1'b1;
        end else begin
`ifdef UPDN_COUNTER_STEP_EDGE_EN
            us_e = up_step && !hist_up;
            ds_e = dn_step && !hist_dn;
`else
            us_e = up_step;
            ds_e = dn_step;
`endif
            upe = run || us_e;
            dne = ds_e;
            m16 = next_val(m16, 65535, int'(din16), upe, dne, w16);
            m4  = next_val(m4, 9, int'(din4), upe, dne, w4);
            hist_up = up_step;
            hist_dn = dn_step;
        end
        e.q16 = m16; e.u16 = (m16 == 65535); e.d16 = (m16 == 0); e.w16 = w16;
        e.q4  = m4;  e.u4  = (m4 == 9);      e.d4  = (m4 == 0);  e.w4  = w4;
        sb.push_back(e);
    endtask

    task automatic apply(bit r, bit c, bit rn, bit us, bit ds, bit l, bit s,
                         logic [15:0] d16, logic [3:0] d4);
        reset = r; ce = c; run = rn; up_step = us; dn_step = ds;
        ld = l; sat = s; din16 = d16; din4 = d4;
        model_step();
        @(negedge clk);
    endtask

    // Monitor: the counter presents a fresh output every clock.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("q16", 32'(q16), 32'(e.q16));
                chk("utc16", 32'(utc16), 32'(e.u16));
                chk("dtc16", 32'(dtc16), 32'(e.d16));
                chk("wrap16", 32'(wp16), 32'(e.w16));
                chk("q4", 32'(q4), 32'(e.q4));
                chk("utc4", 32'(utc4), 32'(e.u4));
                chk("dtc4", 32'(dtc4), 32'(e.d4));
                chk("wrap4", 32'(wp4), 32'(e.w4));
            end
        end
    end

    initial begin
        bit r, c, rn, us, ds, l, s;
        logic [15:0] d16;
        reset = 1; ce = 0; run = 0; up_step = 0; dn_step = 0;
        ld = 0; sat = 0; din16 = '0; din4 = '0;
        apply(1, 0, 0, 0, 0, 0, 0, 16'h0, 4'h0);
        apply(1, 0, 0, 0, 0, 0, 0, 16'h0, 4'h0);
        apply(0, 1, 0, 0, 0, 0, 0, 16'h0, 4'h0);
        // Load, then wrap through the top of the 16-bit range.
        apply(0, 1, 0, 0, 0, 1, 0, 16'h9034, 4'h3);
        chk("load_9034", 32'(q16), 32'h9034);
        apply(0, 1, 0, 0, 0, 1, 0, 16'hFFFE, 4'h8);
        repeat (3) apply(0, 1, 1, 0, 0, 0, 0, 16'h0, 4'h0);
        chk("wrap_seq_end", 32'(q16), 32'h0001);
        // Held step: edge build counts once per press, level build every cycle.
        apply(0, 1, 0, 0, 0, 1, 0, 16'h0100, 4'h0);
        repeat (2) begin
            repeat (5) apply(0, 1, 0, 1, 0, 0, 0, 16'h0, 4'h0);
            repeat (3) apply(0, 1, 0, 0, 0, 0, 0, 16'h0, 4'h0);
        end
`ifdef UPDN_COUNTER_STEP_EDGE_EN
        chk("held_step_delta", 32'(q16), 32'h0102);
`else
        chk("held_step_delta", 32'(q16), 32'h010A);
`endif
        // Saturation at both bounds and load clamping on the modulo-10 unit.
        apply(0, 1, 0, 0, 0, 1, 1, 16'hFFFF, 4'h9);
        apply(0, 1, 0, 1, 0, 0, 1, 16'h0, 4'h0);
        chk("sat_hold_9", 32'(q4), 32'd9);
        chk("sat_utc", 32'(utc4), 32'd1);
        apply(0, 1, 0, 0, 0, 1, 1, 16'h0, 4'h0);
        apply(0, 1, 0, 0, 1, 0, 1, 16'h0, 4'h0);
        chk("sat_hold_0", 32'(q4), 32'd0);
        apply(0, 1, 0, 0, 0, 1, 1, 16'h0, 4'hC);
        chk("load_clamp", 32'(q4), 32'd9);
        // Opposing steps, disabled counting, load while disabled.
        apply(0, 1, 0, 0, 0, 1, 0, 16'h0050, 4'h5);
        apply(0, 1, 0, 1, 1, 0, 0, 16'h0, 4'h0);
        chk("both_steps_hold", 32'(q16), 32'h0050);
        repeat (4) apply(0, 0, 1, 0, 0, 0, 0, 16'h0, 4'h0);
        chk("ce_off_hold", 32'(q16), 32'h0050);
        apply(0, 0, 1, 0, 0, 1, 0, 16'h0777, 4'h2);
        chk("ld_ce_off", 32'(q16), 32'h0777);
        // Reset mid-count with a step held through release.
        apply(0, 1, 0, 0, 0, 1, 0, 16'h1234, 4'h4);
        apply(0, 1, 1, 1, 0, 0, 0, 16'h0, 4'h0);
        apply(1, 1, 1, 1, 0, 0, 0, 16'h0, 4'h0);
        chk("reset_mid", 32'(q16), 32'h0);
        repeat (3) apply(0, 1, 0, 1, 0, 0, 0, 16'h0, 4'h0);
`ifdef UPDN_COUNTER_STEP_EDGE_EN
        chk("held_through_reset", 32'(q16), 32'h0);
`else
        chk("held_through_reset", 32'(q16), 32'h3);
`endif
        // Randomized traffic, biased towards the bounds.
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(99) == 0);
            c  = ($urandom_range(7) != 0);
            rn = ($urandom_range(3) == 0);
            us = ($urandom_range(2) == 0);
            ds = ($urandom_range(2) == 0);
            l  = ($urandom_range(15) == 0);
            s  = ($urandom_range(1) == 1);
            case ($urandom_range(3))
                0: d16 = 16'hFFFF;
                1: d16 = 16'hFFFE;
                2: d16 = 16'h0001;
                default: d16 = 16'($urandom);
            endcase
            apply(r, c, rn, us, ds, l, s, d16, 4'($urandom_range(15)));
        end
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
